// File: rtl/timer_bus_master.sv
// timer_bus_master
//   Command-driven initiator for the timer register bus. It accepts one
//   register-access command at a time (WRITE, READ, read-modify-write, POLL),
//   drives the module_en/wr/addr/wdata strobes, captures rdata and returns
//   one response per command.
//
//   State table:
//     state  | meaning
//     IDLE   | waiting for a command, cmd_ready=1
//     RD     | bus read cycle, rdata sampled at the closing edge
//     WR     | bus write cycle (WRITE data or RMW merged value)
//     GAP    | one idle bus cycle between POLL reads
//     RESP   | response held until rsp_ready
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_op/addr/data/mask     command fields (op: 0=WRITE 1=READ 2=RMW 3=POLL)
//   rsp_valid/rsp_ready       response handshake
//   rsp_data, rsp_timeout     response payload
//   module_en, wr, addr,
//   wdata, rdata              timer register bus
module timer_bus_master #(
  parameter int POLL_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic [7:0] cmd_mask,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       module_en,
  output logic       wr,
  output logic [5:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_GAP,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_RMW   = 2'd2;
  localparam logic [1:0] OP_POLL  = 2'd3;

  localparam logic [7:0] POLL_LIMIT_B = 8'(POLL_LIMIT);

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [5:0] caddr_q, caddr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] poll_cnt_q, poll_cnt_d;

  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_timeout_q, rsp_timeout_d;
  logic       module_en_q, module_en_d;
  logic       wr_q, wr_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

  logic [7:0] wval;
  logic       poll_match;
  logic [7:0] poll_cnt_inc;
  logic [5:0] bus_addr_nxt;
  logic [7:0] bus_wdata_nxt;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    caddr_d       = caddr_q;
    data_d        = data_q;
    mask_d        = mask_q;
    poll_cnt_d    = poll_cnt_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;

    wval          = (rdata & ~mask_q) | (data_q & mask_q);
    poll_match    = ((rdata ^ data_q) & mask_q) == 8'h00;
    poll_cnt_inc  = poll_cnt_q + 8'd1;
    bus_addr_nxt  = caddr_q;
    bus_wdata_nxt = data_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d          = cmd_op;
          caddr_d       = cmd_addr;
          data_d        = cmd_data;
          mask_d        = cmd_mask;
          poll_cnt_d    = 8'h00;
          // The first bus cycle starts right after the accept edge, so the
          // bus registers are loaded from the command inputs directly.
          bus_addr_nxt  = cmd_addr;
          bus_wdata_nxt = cmd_data;
          state_d       = (cmd_op == OP_WRITE) ? S_WR : S_RD;
        end
      end
      S_RD: begin
        case (op_q)
          OP_RMW: begin
            bus_wdata_nxt = wval;
            state_d       = S_WR;
          end
          OP_POLL: begin
            if (poll_match) begin
              rsp_data_d    = rdata;
              rsp_timeout_d = 1'b0;
              state_d       = S_RESP;
            end else begin
              poll_cnt_d = poll_cnt_inc;
              if (poll_cnt_inc == POLL_LIMIT_B) begin
                rsp_data_d    = rdata;
                rsp_timeout_d = 1'b1;
                state_d       = S_RESP;
              end else begin
                state_d = S_GAP;
              end
            end
          end
          default: begin
            rsp_data_d    = rdata;
            rsp_timeout_d = 1'b0;
            state_d       = S_RESP;
          end
        endcase
      end
      S_WR: begin
        // wdata_q holds the byte actually written (WRITE data or RMW merge).
        rsp_data_d    = wdata_q;
        rsp_timeout_d = 1'b0;
        state_d       = S_RESP;
      end
      S_GAP: begin
        state_d = S_RD;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    module_en_d = (state_d == S_RD) || (state_d == S_WR);
    wr_d        = (state_d == S_WR);
    addr_d      = module_en_d ? bus_addr_nxt : 6'h00;
    wdata_d     = wr_d ? bus_wdata_nxt : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= OP_WRITE;
      caddr_q       <= 6'h00;
      data_q        <= 8'h00;
      mask_q        <= 8'h00;
      poll_cnt_q    <= 8'h00;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'h00;
      rsp_timeout_q <= 1'b0;
      module_en_q   <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= 6'h00;
      wdata_q       <= 8'h00;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      caddr_q       <= caddr_d;
      data_q        <= data_d;
      mask_q        <= mask_d;
      poll_cnt_q    <= poll_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      module_en_q   <= module_en_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign module_en   = module_en_q;
  assign wr          = wr_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;

endmodule

// File: tb/tb_timer_bus_master.sv
// Directed bench for timer_bus_master with a small register-file responder.
module tb_timer_bus_master;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [7:0] cmd_mask;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic       module_en;
  logic       wr;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  int checks = 0;
  int failures = 0;

  timer_bus_master #(.POLL_LIMIT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .module_en(module_en), .wr(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: plain memory except address 0x04, a status register whose
  // content depends on poll_mode and on how many reads it has seen.
  logic [7:0] mem [64];
  int rd_cnt = 0;
  int wr_cnt = 0;
  int rd4_cnt = 0;
  int rd4_base = 0;
  int poll_mode = 0;
  int bad_b2b = 0;
  logic prev_en = 1'b0;
  logic prev_wr = 1'b0;
  logic [7:0] stat;

  always_comb begin
    stat = 8'h00;
    if (poll_mode == 1) stat = ((rd4_cnt - rd4_base) >= 2) ? 8'h02 : 8'h00;
    else if (poll_mode == 2) stat = 8'h03;
  end

  assign rdata = (addr == 6'h04) ? stat : mem[addr];

  always @(posedge clk) begin
    if (!rst && module_en) begin
      if (wr) begin
        mem[addr] <= wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        rd_cnt <= rd_cnt + 1;
        if (addr == 6'h04) rd4_cnt <= rd4_cnt + 1;
      end
      if (prev_en && !(!prev_wr && wr)) bad_b2b <= bad_b2b + 1;
    end
    prev_en <= module_en;
    prev_wr <= wr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command, checks it can be accepted, crosses the accept edge.
  task automatic issue(input logic [1:0] op, input logic [5:0] a,
                       input logic [7:0] d, input logic [7:0] m);
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_mask  = m;
    cmd_valid = 1'b1;
    chk("accept_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Called in cycle 1; returns the cycle in which rsp_valid is first seen.
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  int cyc;
  int rd_base;
  int wr_base;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = 8'h30;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 6'h00;
    cmd_data  = 8'h00;
    cmd_mask  = 8'h00;
    rsp_ready = 1'b1;

    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_module_en", module_en, 0);
    chk("rst_bus", {wr, addr, wdata}, 15'h0);
    @(posedge clk); #1 rst = 1'b0;
    step();

    // WRITE 0x0A <= 0x7F
    issue(2'd0, 6'h0A, 8'h7F, 8'h00);
    chk("wr_c1_en", module_en, 1);
    chk("wr_c1_wr", wr, 1);
    chk("wr_c1_addr", addr, 6'h0A);
    chk("wr_c1_wdata", wdata, 8'h7F);
    chk("wr_c1_ready", cmd_ready, 0);
    chk("wr_c1_rsp", rsp_valid, 0);
    step();
    chk("wr_c2_rsp", rsp_valid, 1);
    chk("wr_c2_data", rsp_data, 8'h7F);
    chk("wr_c2_to", rsp_timeout, 0);
    chk("wr_c2_en", module_en, 0);
    chk("wr_mem", mem[10], 8'h7F);
    step();
    chk("wr_c3_ready", cmd_ready, 1);
    chk("wr_c3_rsp", rsp_valid, 0);

    // READ 0x0A
    issue(2'd1, 6'h0A, 8'h00, 8'h00);
    chk("rd_c1_en", module_en, 1);
    chk("rd_c1_wr", wr, 0);
    chk("rd_c1_addr", addr, 6'h0A);
    chk("rd_c1_wdata", wdata, 8'h00);
    step();
    chk("rd_c2_rsp", rsp_valid, 1);
    chk("rd_c2_data", rsp_data, 8'h7F);
    chk("rd_c2_en", module_en, 0);
    step();

    // RMW 0x00: 0x30 with bit0 set -> 0x31
    issue(2'd2, 6'h00, 8'h01, 8'h01);
    chk("rmw_c1_rd", {module_en, wr}, 2'b10);
    chk("rmw_c1_addr", addr, 6'h00);
    step();
    chk("rmw_c2_wr", {module_en, wr}, 2'b11);
    chk("rmw_c2_wdata", wdata, 8'h31);
    chk("rmw_c2_rsp", rsp_valid, 0);
    step();
    chk("rmw_c3_rsp", rsp_valid, 1);
    chk("rmw_c3_data", rsp_data, 8'h31);
    chk("rmw_c3_to", rsp_timeout, 0);
    chk("rmw_mem", mem[0], 8'h31);
    step();

    // POLL 0x04 for bit1, set on the third read
    rd4_base  = rd4_cnt;
    poll_mode = 1;
    rd_base   = rd_cnt;
    issue(2'd3, 6'h04, 8'h02, 8'h02);
    wait_rsp(cyc);
    chk("poll1_rsp", rsp_valid, 1);
    chk("poll1_cycle", cyc, 6);
    chk("poll1_reads", rd_cnt - rd_base, 3);
    chk("poll1_to", rsp_timeout, 0);
    chk("poll1_data", rsp_data, 8'h02);
    step();

    // POLL 0x04 for bit2, never set -> timeout after 16 reads
    poll_mode = 2;
    rd_base   = rd_cnt;
    issue(2'd3, 6'h04, 8'h04, 8'h04);
    wait_rsp(cyc);
    chk("poll2_rsp", rsp_valid, 1);
    chk("poll2_cycle", cyc, 32);
    chk("poll2_reads", rd_cnt - rd_base, 16);
    chk("poll2_to", rsp_timeout, 1);
    chk("poll2_data", rsp_data, 8'h03);
    step();
    chk("poll2_idle_to", cmd_ready, 1);
    poll_mode = 0;

    // Response back-pressure, with a READ presented during the hold
    rsp_ready = 1'b0;
    issue(2'd0, 6'h10, 8'h55, 8'h00);
    step();
    cmd_op    = 2'd1;
    cmd_addr  = 6'h0A;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp", rsp_valid, 1);
      chk("hold_data", rsp_data, 8'h55);
      chk("hold_ready", cmd_ready, 0);
      chk("hold_en", module_en, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("hold_rel_ready", cmd_ready, 1);
    chk("hold_rel_rsp", rsp_valid, 0);
    step();
    cmd_valid = 1'b0;
    chk("next_rd_en", {module_en, wr}, 2'b10);
    chk("next_rd_addr", addr, 6'h0A);
    step();
    chk("next_rd_data", rsp_data, 8'h7F);
    chk("next_rd_to", rsp_timeout, 0);
    step();

    // Reset during the RMW read cycle
    issue(2'd2, 6'h00, 8'h80, 8'h80);
    chk("rst_rmw_c1", module_en, 1);
    wr_base = wr_cnt;
    rst = 1'b1;
    #1;
    chk("rst_mid_en", module_en, 0);
    chk("rst_mid_bus", {wr, addr, wdata}, 15'h0);
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_rsp", {rsp_valid, rsp_timeout, rsp_data}, 10'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("rst_no_write", wr_cnt - wr_base, 0);
    chk("rst_mem", mem[0], 8'h31);
    chk("rst_after_ready", cmd_ready, 1);
    chk("rst_after_en", module_en, 0);

    chk("no_b2b_access", bad_b2b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
